// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-cycle done pulse; define AUTO_RELOAD_EN for periodic reload
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             res,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] count_n;
  logic done_n;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_n;
`endif
  assign busy = state == RUN;
  assign load_ready = state == IDLE;
  // next state: load in IDLE, abort beats expiry, decrement gated at count==1
  always_comb begin
    state_n = state;
    count_n = count;
    done_n = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_n = reload;
`endif
    if (state == IDLE) begin
      if (load_valid) begin
        count_n = load_value;
        state_n = load_value == '0 ? IDLE : RUN;
        done_n = load_value == '0;
`ifdef AUTO_RELOAD_EN
        reload_n = load_value;
`endif
      end
    end else if (abort) begin
      count_n = '0;
      state_n = IDLE;
    end else if (enable) begin
      done_n = count == WIDTH'(1);
`ifdef AUTO_RELOAD_EN
      count_n = done_n ? reload : count - WIDTH'(1);
`else
      count_n = count - WIDTH'(1);
      state_n = done_n ? IDLE : RUN;
`endif
    end
  end
  // state, count and done registers with synchronous reset
  always_ff @(posedge clock) begin
    if (res) begin
      state <= IDLE;
      count <= '0;
      done <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_n;
      count <= count_n;
      done <= done_n;
`ifdef AUTO_RELOAD_EN
      reload <= reload_n;
`endif
    end
  end
endmodule
